// File: rtl/riscv_idex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards EX/MEM and MEM/WB
// results into the ALU operands, and stalls on load-use hazards.
module riscv_idex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_uses_rs1,
  input  logic            in_uses_rs2,
  input  logic            in_alu_src_imm,
  input  logic [3:0]      in_alu_ctrl,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            exmem_wen,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            exmem_is_load,
  input  logic            memwb_wen,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_pc,
  output logic [REGW-1:0] out_rd,
  output logic            out_reg_write
);

  // Handshake: a transfer happens on a side when its valid and ready are both high
  // at the clock edge; valid never depends on ready of the same side.
  logic            valid;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [REGW-1:0] rs1_q, rs2_q, rd_q;
  logic            uses_rs1_q, uses_rs2_q, alu_src_imm_q, reg_write_q;
  logic [3:0]      alu_ctrl_q;

  logic ex_m1, ex_m2, wb_m1, wb_m2, hz, fire_out, fire_in;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign ex_m1 = exmem_wen && (exmem_rd == rs1_q) && (rs1_q != '0);
  assign ex_m2 = exmem_wen && (exmem_rd == rs2_q) && (rs2_q != '0);
  assign wb_m1 = memwb_wen && (memwb_rd == rs1_q) && (rs1_q != '0);
  assign wb_m2 = memwb_wen && (memwb_rd == rs2_q) && (rs2_q != '0);

  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (ex_m1)      fwd_rs1 = exmem_data;
    else if (wb_m1) fwd_rs1 = memwb_data;
    fwd_rs2 = rs2_data_q;
    if (ex_m2)      fwd_rs2 = exmem_data;
    else if (wb_m2) fwd_rs2 = memwb_data;
  end

  assign hz = valid && exmem_is_load &&
              ((uses_rs1_q && ex_m1) || (uses_rs2_q && ex_m2));

  assign out_valid     = valid && !hz;
  assign fire_out      = out_valid && out_ready;
  assign in_ready      = !valid || fire_out;
  assign fire_in       = in_valid && in_ready;

  assign alu_a         = fwd_rs1;
  assign alu_b         = alu_src_imm_q ? imm_q : fwd_rs2;
  assign out_rs2_data  = fwd_rs2;
  assign alu_ctrl      = alu_ctrl_q;
  assign out_pc        = pc_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid         <= 1'b0;
      pc_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      uses_rs1_q    <= 1'b0;
      uses_rs2_q    <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_ctrl_q    <= '0;
      reg_write_q   <= 1'b0;
    end else if (flush) begin
      valid       <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (fire_in) begin
      valid         <= 1'b1;
      pc_q          <= in_pc;
      rs1_data_q    <= in_rs1_data;
      rs2_data_q    <= in_rs2_data;
      imm_q         <= in_imm;
      rs1_q         <= in_rs1;
      rs2_q         <= in_rs2;
      rd_q          <= in_rd;
      uses_rs1_q    <= in_uses_rs1;
      uses_rs2_q    <= in_uses_rs2;
      alu_src_imm_q <= in_alu_src_imm;
      alu_ctrl_q    <= in_alu_ctrl;
      reg_write_q   <= in_reg_write;
    end else if (fire_out) begin
      valid <= 1'b0;
    end else if (valid) begin
      // A result retiring from MEM/WB during a stall would otherwise be lost.
      if (wb_m1) rs1_data_q <= memwb_data;
      if (wb_m2) rs2_data_q <= memwb_data;
    end
  end

endmodule

// File: tb/tb_riscv_idex_stage.sv
// Directed bench for riscv_idex_stage: table of forwarding/hazard vectors plus
// hand-written sequences for reset, load-use, stall snoop and streaming with flush.
module tb_riscv_idex_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_alu_src_imm, in_reg_write;
  logic [3:0]  in_alu_ctrl;
  logic        flush;
  logic        exmem_wen, exmem_is_load;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_wen;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, out_rs2_data, out_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  riscv_idex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_alu_src_imm(in_alu_src_imm), .in_alu_ctrl(in_alu_ctrl), .in_reg_write(in_reg_write),
    .flush(flush),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .exmem_is_load(exmem_is_load),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        src, u1, u2;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic        xl;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [31:0] ea, eb, es;
    logic        ev;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_fwd();
    exmem_wen = 1'b0; exmem_rd = '0; exmem_data = '0; exmem_is_load = 1'b0;
    memwb_wen = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  // Called just after a posedge with the stage empty; returns just after the capture edge.
  task automatic load(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic u1, input logic u2, input logic src,
                      input logic [3:0] ctrl, input logic rw);
    idle_fwd();
    out_ready = 1'b0;
    in_pc = pc; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_alu_src_imm = src;
    in_alu_ctrl = ctrl; in_reg_write = rw;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    idle_fwd();
    out_ready = 1'b1;
    #1 check("drain_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec[0] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 100, 1'b0, 1'b0, 5'd0, 0, 100, 6, 6, 1'b1};
    vec[1] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 100, 1'b0, 1'b1, 5'd3, 200, 100, 6, 6, 1'b1};
    vec[2] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 0, 1'b0, 1'b1, 5'd4, 200, 5, 200, 200, 1'b1};
    vec[3] = '{5'd0, 5'd4, 'h11, 6, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 'hDEAD, 1'b0, 1'b0, 5'd0, 0, 'h11, 6, 6, 1'b1};
    vec[4] = '{5'd3, 5'd4, 5, 6, 'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 'h99, 1'b0, 1'b0, 5'd0, 0, 5, 'hFFFFFFF0, 'h99, 1'b1};
    vec[5] = '{5'd3, 5'd9, 5, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 'h33, 1'b1, 1'b0, 5'd0, 0, 5, 'h33, 'h33, 1'b0};
    vec[6] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 'h42, 1'b1, 1'b0, 5'd0, 0, 'h42, 6, 6, 1'b1};
    vec[7] = '{5'd0, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 'h42, 1'b1, 1'b0, 5'd0, 0, 5, 6, 6, 1'b1};
    vec[8] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 100, 1'b0, 1'b0, 5'd0, 0, 5, 6, 6, 1'b1};
    vec[9] = '{5'd3, 5'd4, 5, 6, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 'hAA, 1'b0, 1'b1, 5'd3, 'hBB, 'hBB, 'hAA, 'hAA, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_alu_src_imm = 1'b0;
    in_alu_ctrl = '0; in_reg_write = 1'b0;
    idle_fwd();
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rw", 32'(out_reg_write), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_rd", 32'(out_rd), 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_rs2", out_rs2_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // table-driven forwarding / hazard vectors
    for (int i = 0; i < NV; i++) begin
      load(32'h1000 + 32'(i) * 4, vec[i].d1, vec[i].d2, vec[i].imm, vec[i].rs1, vec[i].rs2,
           5'(i + 1), vec[i].u1, vec[i].u2, vec[i].src, 4'(i), 1'b1);
      exmem_wen = vec[i].xw; exmem_rd = vec[i].xrd; exmem_data = vec[i].xd;
      exmem_is_load = vec[i].xl;
      memwb_wen = vec[i].mw; memwb_rd = vec[i].mrd; memwb_data = vec[i].md;
      #1;
      check($sformatf("v%0d_a", i), alu_a, vec[i].ea);
      check($sformatf("v%0d_b", i), alu_b, vec[i].eb);
      check($sformatf("v%0d_rs2", i), out_rs2_data, vec[i].es);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vec[i].ev));
      check($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(i));
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(i + 1));
      check($sformatf("v%0d_rw", i), 32'(out_reg_write), 32'd1);
      drain();
    end

    // load-use bubble resolved by the load reaching MEM/WB
    load(32'h3000, 32'h1, 32'h2, 32'h0, 5'd1, 5'd9, 5'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    exmem_wen = 1'b1; exmem_is_load = 1'b1; exmem_rd = 5'd9; exmem_data = 32'hBAD;
    out_ready = 1'b1;
    #1;
    check("lu_valid", 32'(out_valid), 32'd0);
    check("lu_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    idle_fwd();
    memwb_wen = 1'b1; memwb_rd = 5'd9; memwb_data = 32'h55;
    #1;
    check("lu2_valid", 32'(out_valid), 32'd1);
    check("lu2_b", alu_b, 32'h55);
    check("lu2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle_fwd(); out_ready = 1'b0;
    check("lu_done", 32'(out_valid), 32'd0);

    // stall snoop: MEM/WB value present for one cycle only
    load(32'h3100, 32'h10, 32'h20, 32'h0, 5'd2, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
    memwb_wen = 1'b1; memwb_rd = 5'd2; memwb_data = 32'h77;
    #1 check("snoop_c1_a", alu_a, 32'h77);
    @(posedge clk); #1;
    idle_fwd();
    #1 check("snoop_c2_a", alu_a, 32'h77);
    check("snoop_c2_rs2", out_rs2_data, 32'h20);
    @(posedge clk); #1;
    check("snoop_c3_a", alu_a, 32'h77);
    out_ready = 1'b1;
    #1;
    check("snoop_fire_a", alu_a, 32'h77);
    check("snoop_fire_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("snoop_done", 32'(out_valid), 32'd0);

    // asynchronous reset while holding an instruction
    load(32'h3200, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    check("ar_pre_rw", 32'(out_reg_write), 32'd1);
    check("ar_pre_rd", 32'(out_rd), 32'd7);
    #1 rst = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_rw", 32'(out_reg_write), 32'd0);
    check("ar_rd", 32'(out_rd), 32'd0);
    check("ar_ctrl", 32'(alu_ctrl), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // streaming four instructions, then flush together with a fifth
    for (int c = 0; c < 7; c++) begin
      out_ready = 1'b1;
      if (c < 5) begin
        in_pc = 32'h2000 + 32'(c) * 4; in_rd = 5'(c + 1); in_reg_write = 1'b1;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0;
        in_valid = 1'b1;
        flush = (c == 4);
        if (c < 4) exp_q.push_back(in_pc);
      end else begin
        in_valid = 1'b0; flush = 1'b0;
      end
      #1;
      if (c >= 1 && c <= 4) begin
        check($sformatf("st%0d_valid", c), 32'(out_valid), 32'd1);
        if (exp_q.size() > 0) check($sformatf("st%0d_pc", c), out_pc, exp_q.pop_front());
        else check($sformatf("st%0d_q", c), 32'(exp_q.size()), 32'd1);
        check($sformatf("st%0d_in_ready", c), 32'(in_ready), 32'd1);
      end
      if (c >= 5) begin
        check($sformatf("st%0d_flushed", c), 32'(out_valid), 32'd0);
        check($sformatf("st%0d_rw", c), 32'(out_reg_write), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("st_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
